// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: owner encoding and defaults.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int ADDR_W_DEF     = 12;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_resp.sv
// Response side of the arbiter: remembers who owned the last RAM cycle, raises
// that requester's Valid and returns the RAM data, with per-requester holds.
import mem_arb_pkg::*;

module mem_arb_resp (
  input  logic        clk,
  input  logic        rstn,
  input  owner_e      grantOwner,
  input  logic        grantWrite,
  input  logic [31:0] memRData,
  output logic        ifValid,
  output logic [31:0] ifData,
  output logic        dValid,
  output logic [31:0] dData
);

  owner_e      pendOwner;
  logic        pendWrite;
  logic [31:0] ifHold;
  logic [31:0] dHold;

  // Owner of the issuing cycle; reset drops any response still in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pendOwner <= OWN_NONE;
      pendWrite <= 1'b0;
    end else begin
      pendOwner <= grantOwner;
      pendWrite <= grantWrite;
    end
  end

  assign ifValid = (pendOwner == OWN_IF);
  assign dValid  = (pendOwner == OWN_D);

  // Keep the last read word visible after Valid drops; write acks leave D hold alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifHold <= '0;
      dHold  <= '0;
    end else begin
      if (ifValid)               ifHold <= memRData;
      if (dValid && !pendWrite)  dHold  <= memRData;
    end
  end

  assign ifData = ifValid ? memRData : ifHold;
  assign dData  = dValid  ? memRData : dHold;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM shared by
// instruction fetch (IF) and the load/store stage (D). D has priority; IF is
// forced through after STARVE_MAX consecutive denied cycles.
// Optional macro MEM_ARB_PERF_CNT_EN builds the IF-stall and conflict counters.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_IFReq_1,
  input  logic [31:0]       i_IFAddr_32,
  output logic              o_IFGnt_1,
  output logic              o_IFValid_1,
  output logic [31:0]       o_IFData_32,
  input  logic              i_DReq_1,
  input  logic              i_DWen_1,
  input  logic [3:0]        i_DWstrb_4,
  input  logic [31:0]       i_DAddr_32,
  input  logic [31:0]       i_DWData_32,
  output logic              o_DGnt_1,
  output logic              o_DValid_1,
  output logic [31:0]       o_DData_32,
  output logic              o_MemEn_1,
  output logic [3:0]        o_MemWe_4,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [31:0]       o_MemWData_32,
  input  logic [31:0]       i_MemRData_32,
  output logic              o_IFStall_1,
  output logic [31:0]       o_IFStallCnt_32,
  output logic [31:0]       o_DConflictCnt_32
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic   [3:0] starveCnt;
  logic         starveHit;
  logic         ifGnt;
  logic         dGnt;
  logic         grantWrite;
  owner_e       grantOwner;

  // Byte offset and bits above the RAM depth are deliberately dropped (addresses wrap).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{i_IFAddr_32[31:ADDR_W+2], i_IFAddr_32[1:0],
                            i_DAddr_32[31:ADDR_W+2],  i_DAddr_32[1:0]};

  // Grants are gated by rstn so nothing reaches the RAM while in reset.
  assign starveHit  = (starveCnt == STARVE_LIM);
  assign ifGnt      = rstn & i_IFReq_1 & (~i_DReq_1 | starveHit);
  assign dGnt       = rstn & i_DReq_1 & ~ifGnt;
  assign grantWrite = dGnt & i_DWen_1;

  assign o_IFGnt_1     = ifGnt;
  assign o_DGnt_1      = dGnt;
  assign o_IFStall_1   = i_IFReq_1 & ~ifGnt;
  assign o_MemEn_1     = ifGnt | dGnt;
  assign o_MemWe_4     = grantWrite ? i_DWstrb_4 : 4'b0000;
  assign o_MemAddr     = ifGnt ? i_IFAddr_32[ADDR_W+1:2] : i_DAddr_32[ADDR_W+1:2];
  assign o_MemWData_32 = i_DWData_32;

  // Owner of this cycle, handed to the response side.
  always_comb begin
    grantOwner = OWN_NONE;
    if (ifGnt)     grantOwner = OWN_IF;
    else if (dGnt) grantOwner = OWN_D;
  end

  // Count consecutive denied IF cycles; saturate at the limit, clear otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     starveCnt <= '0;
    else if (i_IFReq_1 && !ifGnt)  starveCnt <= starveHit ? starveCnt : starveCnt + 4'd1;
    else                           starveCnt <= '0;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] ifStallCnt;
  logic [31:0] dConflictCnt;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifStallCnt   <= '0;
      dConflictCnt <= '0;
    end else begin
      if (o_IFStall_1)           ifStallCnt   <= ifStallCnt + 32'd1;
      if (i_IFReq_1 && i_DReq_1) dConflictCnt <= dConflictCnt + 32'd1;
    end
  end

  assign o_IFStallCnt_32   = ifStallCnt;
  assign o_DConflictCnt_32 = dConflictCnt;
`else
  assign o_IFStallCnt_32   = 32'd0;
  assign o_DConflictCnt_32 = 32'd0;
`endif

  mem_arb_resp uResp (
    .clk        (clk),
    .rstn       (rstn),
    .grantOwner (grantOwner),
    .grantWrite (grantWrite),
    .memRData   (i_MemRData_32),
    .ifValid    (o_IFValid_1),
    .ifData     (o_IFData_32),
    .dValid     (o_DValid_1),
    .dData      (o_DData_32)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous block RAM between two requesters: instruction fetch (IF) and the memory stage's load/store (D).
- Sits between instfetch/memory and a unified code+data RAM, replacing the separate IRom/DRam pair.
- Fixed priority to D, with an IF anti-starvation counter.
- Routes 1-cycle-latency read data back to the requester that owned the issuing cycle.

Parameters:
- ADDR_W, 12, word-address width of the RAM.
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced to win one cycle (legal range 1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- i_IFReq_1  in  1  IF read request
- i_IFAddr_32  in  32  IF byte address
- o_IFGnt_1  out  1  IF granted this cycle
- o_IFValid_1  out  1  IF read data valid
- o_IFData_32  out  32  IF read data
- i_DReq_1  in  1  D access request
- i_DWen_1  in  1  D write (1) / read (0)
- i_DWstrb_4  in  4  D byte write strobes
- i_DAddr_32  in  32  D byte address
- i_DWData_32  in  32  D write data
- o_DGnt_1  out  1  D granted this cycle
- o_DValid_1  out  1  D response (read data valid / write done)
- o_DData_32  out  32  D read data
- o_MemEn_1  out  1  RAM enable
- o_MemWe_4  out  4  RAM byte write enables
- o_MemAddr  out  ADDR_W  RAM word address
- o_MemWData_32  out  32  RAM write data
- i_MemRData_32  in  32  RAM read data, 1 cycle after enable
- o_IFStall_1  out  1  IF requested but not granted (to fetch/pipeline stall logic)
- o_IFStallCnt_32  out  32  performance counter (see Optional Feature)
- o_DConflictCnt_32  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset, asynchronous on rstn low:
  - starve counter = 0; pending owner = NONE.
  - Hold registers = 0; perf counters = 0.
  - All Valid outputs = 0.
  - Combinational outputs follow their inputs during reset, but Gnt/MemEn are forced 0.
- Grant is combinational, in the same cycle as the request:
  - Only D requests -> D granted.
  - Only IF requests -> IF granted.
  - Both request -> D wins, unless starve counter == STARVE_MAX, in which case IF wins.
  - Neither requests -> MemEn = 0.
- Starve counter:
  - Increments when IF requests and is denied, saturating at STARVE_MAX.
  - Clears when IF is granted or IF does not request.
  - o_IFStall_1 = i_IFReq_1 & ~o_IFGnt_1.
- Memory drive:
  - MemAddr = granted addr[ADDR_W+1:2]; upper bits are ignored, so addresses wrap.
  - addr[1:0] is ignored.
  - MemWe = i_DWstrb_4 when D is granted and i_DWen_1 = 1, else 0.
  - MemWData = i_DWData_32.
- Pending owner register:
  - Loaded each cycle with the granted owner (IF, D, NONE).
  - A D write also records D, so that o_DValid_1 pulses as the write acknowledge.
- Responses, in the cycle after grant:
  - o_IFValid_1 = (pending == IF).
  - o_DValid_1 = (pending == D).
- Read data:
  - o_XData_32 = i_MemRData_32 while the matching Valid is high; otherwise the per-requester hold register.
  - The hold register captures i_MemRData_32 on a read Valid.
  - A write acknowledge does not update the D hold register.
- Back-to-back grants: one access per cycle, full throughput; no bubble between owners.
- Requests are not latched: a requester must hold Req/Addr stable until Gnt is seen; a dropped request is simply not served.
- Reset during an access: the pending response is discarded and no Valid fires after rstn rises.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - o_IFStallCnt_32 counts cycles with o_IFStall_1 = 1.
  - o_DConflictCnt_32 counts cycles where both requested.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package mem_arb_pkg:
  - owner encoding OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2;
  - default ADDR_W;
  - default STARVE_MAX.
- One natural sub-module, mem_arb_resp: pending-owner register, Valid generation, hold registers and data return mux.
- Grant logic and starve counter stay in the top.

Test Plan:
- IF-only read, IFAddr=0x10, RAM[4]=0xDEAD0001 -> IFGnt same cycle, MemAddr=4; next cycle IFValid=1, IFData=0xDEAD0001; data held after Valid drops.
- D write Addr=0x20, Wstrb=4'b0011, WData=0x1234ABCD, then D read 0x20 (prior 0) -> MemWe=0011; DValid write ack; read returns 0x0000ABCD.
- Continuous simultaneous IF+D requests, STARVE_MAX=4 -> grant pattern D,D,D,D,IF repeating; IFStall high for 4 of every 5 cycles.
- Alternating grants IF@0x0 then D@0x4 on consecutive cycles -> IFValid and DValid in consecutive cycles, each with the correct word; no cross-delivery.
- rstn pulsed low in the cycle after a D read grant -> no DValid; counters and hold registers are 0 after release.
- MEM_ARB_PERF_CNT_EN defined, 10 cycles of dual request -> DConflictCnt=10, IFStallCnt=8; undefined -> both read 0.
